// File: rtl/skolem_sweep_pkg.sv
// Shared types and constants for the Skolem-function sweep controller.
// Holds the FSM state enum, default sizes and the sweep-length helper.
package skolem_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        HOLD,
        DONE
    } sweep_state_t;

    localparam int DEF_IN_W   = 8;
    localparam int DEF_SETTLE = 0;

    // Cycles from busy rising to done rising for a full sweep.
    function automatic int unsigned sweep_cycles(
        input int unsigned in_w,
        input int unsigned settle
    );
        return (32'd1 << in_w) * (settle + 32'd1);
    endfunction

endpackage

// File: rtl/skolem_sweep_vecgen.sv
// Vector counter for the sweep: clears to zero, steps by one, flags all-ones.
// Ports: clk, rst_n (async active-low), clear, step in; vec, last out.
module skolem_sweep_vecgen
    import skolem_sweep_pkg::*;
#(
    parameter int IN_W = DEF_IN_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            step,
    output logic [IN_W-1:0] vec,
    output logic            last
);

    localparam logic [IN_W-1:0] ONE = 1;

    assign last = &vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec <= '0;
        end else if (clear) begin
            vec <= '0;
        end else if (step) begin
            vec <= vec + ONE;
        end
    end

endmodule

// File: rtl/skolem_sweep_ctrl.sv
// Exhaustive sweep controller for one combinational Skolem candidate netlist.
// Ports: clk, rst_n, start, abort, cand_out, ic_ok, phi_ok in;
//        vec, busy, done, pass, fail_cnt, first_fail, chk_cnt out.
// Build option SKOLEM_SWEEP_STOP_ON_FAIL_EN: end the sweep at the first failure.
module skolem_sweep_ctrl
    import skolem_sweep_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic [IN_W-1:0] vec,
    input  logic            cand_out,
    input  logic            ic_ok,
    input  logic            phi_ok,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [IN_W:0]   fail_cnt,
    output logic [IN_W-1:0] first_fail,
    output logic [IN_W:0]   chk_cnt
);

    localparam logic [IN_W:0] CNT_ONE = 1;

    sweep_state_t state;
    logic [3:0]   hold_cnt;
    logic         accept;
    logic         sample;
    logic         fail;
    logic         stop;
    logic         clear;
    logic         step;
    logic         last;

    // The witness itself is judged by the oracle; it only matters through phi_ok.
    logic         unused_cand;
    assign unused_cand = cand_out;

    always_comb begin
        accept = start & ((state == IDLE) | (state == DONE));
        sample = 1'b0;
        if (state == DRIVE) begin
            sample = (SETTLE == 0);
        end else if (state == HOLD) begin
            sample = (hold_cnt == 4'd1);
        end
        fail = ic_ok & ~phi_ok;
`ifdef SKOLEM_SWEEP_STOP_ON_FAIL_EN
        stop = fail;
`else
        stop = 1'b0;
`endif
        clear = abort | accept;
        // vec freezes on the last vector or on a stopping failure.
        step = ~abort & sample & ~last & ~stop;
    end

    skolem_sweep_vecgen #(
        .IN_W (IN_W)
    ) u_vecgen (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .step  (step),
        .vec   (vec),
        .last  (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_cnt   <= '0;
            chk_cnt    <= '0;
            first_fail <= '0;
        end else if (abort) begin
            // Results survive an abort; only the sweep position is dropped.
            state    <= IDLE;
            hold_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= DRIVE;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        fail_cnt   <= '0;
                        chk_cnt    <= '0;
                        first_fail <= '0;
                    end
                end
                DRIVE: begin
                    if (SETTLE != 0) begin
                        state    <= HOLD;
                        hold_cnt <= 4'(SETTLE);
                    end
                end
                HOLD: begin
                    if (hold_cnt != 4'd1) begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (sample) begin
                if (fail) begin
                    fail_cnt <= fail_cnt + CNT_ONE;
                    if (fail_cnt == '0) begin
                        first_fail <= vec;
                    end
                end
                if (ic_ok) begin
                    chk_cnt <= chk_cnt + CNT_ONE;
                end
                if (last | stop) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= ~fail & (fail_cnt == '0);
                end else begin
                    state <= DRIVE;
                end
            end
        end
    end

endmodule

// File: tb/tb_skolem_sweep_ctrl.sv
// Directed bench for skolem_sweep_ctrl: one instance with SETTLE=0, one with
// SETTLE=3, each fed by a behavioural oracle selected per test.
module tb_skolem_sweep_ctrl;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start_s [2];
    logic         abort_s [2];
    logic         ic_s    [2];
    logic         phi_s   [2];
    logic         busy_s  [2];
    logic         done_s  [2];
    logic         pass_s  [2];
    logic [W-1:0] vec_s   [2];
    logic [W-1:0] ff_s    [2];
    logic [W-1:0] prev_s  [2];
    logic [W:0]   fc_s    [2];
    logic [W:0]   cc_s    [2];
    int           mode    [2];

    int checks = 0;
    int errors = 0;

    skolem_sweep_ctrl #(.IN_W(W), .SETTLE(0)) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_s[0]),
        .abort      (abort_s[0]),
        .vec        (vec_s[0]),
        .cand_out   (phi_s[0]),
        .ic_ok      (ic_s[0]),
        .phi_ok     (phi_s[0]),
        .busy       (busy_s[0]),
        .done       (done_s[0]),
        .pass       (pass_s[0]),
        .fail_cnt   (fc_s[0]),
        .first_fail (ff_s[0]),
        .chk_cnt    (cc_s[0])
    );

    skolem_sweep_ctrl #(.IN_W(W), .SETTLE(3)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_s[1]),
        .abort      (abort_s[1]),
        .vec        (vec_s[1]),
        .cand_out   (phi_s[1]),
        .ic_ok      (ic_s[1]),
        .phi_ok     (phi_s[1]),
        .busy       (busy_s[1]),
        .done       (done_s[1]),
        .pass       (pass_s[1]),
        .fail_cnt   (fc_s[1]),
        .first_fail (ff_s[1]),
        .chk_cnt    (cc_s[1])
    );

    // Oracle modes: 0 ideal, 1 fail at 5A/C3, 2 ic=0 phi=0,
    // 3 ideal with phi glitch in first cycle of each vector, 4 ic=vec[0] phi=0,
    // 5 every vector fails.
    function automatic logic [1:0] oracle(int m, logic [W-1:0] v, logic fresh);
        case (m)
            0: return 2'b11;
            1: return {1'b1, !(v == 8'h5A || v == 8'hC3)};
            2: return 2'b00;
            3: return {1'b1, ~fresh};
            4: return {v[0], 1'b0};
            5: return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    always_comb begin
        {ic_s[0], phi_s[0]} = oracle(mode[0], vec_s[0], vec_s[0] != prev_s[0]);
        {ic_s[1], phi_s[1]} = oracle(mode[1], vec_s[1], vec_s[1] != prev_s[1]);
    end

    always_ff @(posedge clk) begin
        prev_s[0] <= vec_s[0];
        prev_s[1] <= vec_s[1];
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_sweep(input int sel, input int m, output int cyc);
        mode[sel] = m;
        start_s[sel] = 1'b1;
        @(posedge clk);
        #1 start_s[sel] = 1'b0;
        check("start_busy", int'(busy_s[sel]), 1);
        check("start_done", int'(done_s[sel]), 0);
        check("start_vec", int'(vec_s[sel]), 0);
        check("start_chk", int'(cc_s[sel]), 0);
        cyc = 0;
        while (!done_s[sel] && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
            // start while busy must be ignored
            start_s[sel] = (cyc == 50) && !done_s[sel];
        end
        start_s[sel] = 1'b0;
    endtask

    task automatic wait_vec(input int sel, input int v);
        int n = 0;
        while (int'(vec_s[sel]) != v && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_vec", int'(vec_s[sel]), v);
    endtask

    typedef struct {
        int sel;
        int m;
        int cyc;
        int pass_e;
        int fail_e;
        int first_e;
        int chk_e;
        int vec_e;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int n;
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        abort_s[0] = 1'b0;
        abort_s[1] = 1'b0;
        mode[0] = 0;
        mode[1] = 0;
`ifdef SKOLEM_SWEEP_STOP_ON_FAIL_EN
        tbl[0] = '{0, 0,  256, 1,   0, 8'h00, 256, 8'hFF};
        tbl[1] = '{0, 1,   91, 0,   1, 8'h5A,  91, 8'h5A};
        tbl[2] = '{0, 2,  256, 1,   0, 8'h00,   0, 8'hFF};
        tbl[3] = '{0, 4,    2, 0,   1, 8'h01,   1, 8'h01};
        tbl[4] = '{0, 5,    1, 0,   1, 8'h00,   1, 8'h00};
        tbl[5] = '{1, 0, 1024, 1,   0, 8'h00, 256, 8'hFF};
        tbl[6] = '{1, 3, 1024, 1,   0, 8'h00, 256, 8'hFF};
        tbl[7] = '{1, 1,  364, 0,   1, 8'h5A,  91, 8'h5A};
`else
        tbl[0] = '{0, 0,  256, 1,   0, 8'h00, 256, 8'hFF};
        tbl[1] = '{0, 1,  256, 0,   2, 8'h5A, 256, 8'hFF};
        tbl[2] = '{0, 2,  256, 1,   0, 8'h00,   0, 8'hFF};
        tbl[3] = '{0, 4,  256, 0, 128, 8'h01, 128, 8'hFF};
        tbl[4] = '{0, 5,  256, 0, 256, 8'h00, 256, 8'hFF};
        tbl[5] = '{1, 0, 1024, 1,   0, 8'h00, 256, 8'hFF};
        tbl[6] = '{1, 3, 1024, 1,   0, 8'h00, 256, 8'hFF};
        tbl[7] = '{1, 1, 1024, 0,   2, 8'h5A, 256, 8'hFF};
`endif

        // Reset state
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #4;
        for (int s = 0; s < 2; s++) begin
            check("rst_vec", int'(vec_s[s]), 0);
            check("rst_busy", int'(busy_s[s]), 0);
            check("rst_done", int'(done_s[s]), 0);
            check("rst_pass", int'(pass_s[s]), 0);
            check("rst_fail", int'(fc_s[s]), 0);
            check("rst_chk", int'(cc_s[s]), 0);
            check("rst_first", int'(ff_s[s]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven sweeps
        for (int i = 0; i < 8; i++) begin
            run_sweep(tbl[i].sel, tbl[i].m, n);
            check($sformatf("t%0d_cycles", i), n, tbl[i].cyc);
            check($sformatf("t%0d_done", i), int'(done_s[tbl[i].sel]), 1);
            check($sformatf("t%0d_busy", i), int'(busy_s[tbl[i].sel]), 0);
            check($sformatf("t%0d_pass", i), int'(pass_s[tbl[i].sel]), tbl[i].pass_e);
            check($sformatf("t%0d_fail", i), int'(fc_s[tbl[i].sel]), tbl[i].fail_e);
            check($sformatf("t%0d_first", i), int'(ff_s[tbl[i].sel]), tbl[i].first_e);
            check($sformatf("t%0d_chk", i), int'(cc_s[tbl[i].sel]), tbl[i].chk_e);
            check($sformatf("t%0d_vec", i), int'(vec_s[tbl[i].sel]), tbl[i].vec_e);
            @(posedge clk);
            #1;
            check($sformatf("t%0d_hold", i), int'(done_s[tbl[i].sel]), 1);
        end

`ifndef SKOLEM_SWEEP_STOP_ON_FAIL_EN
        // Abort at vec=0x40 with odd vectors failing: counters keep values
        mode[0] = 4;
        start_s[0] = 1'b1;
        @(posedge clk);
        #1 start_s[0] = 1'b0;
        wait_vec(0, 8'h40);
        abort_s[0] = 1'b1;
        @(posedge clk);
        #1 abort_s[0] = 1'b0;
        check("abort_busy", int'(busy_s[0]), 0);
        check("abort_done", int'(done_s[0]), 0);
        check("abort_pass", int'(pass_s[0]), 0);
        check("abort_vec", int'(vec_s[0]), 0);
        check("abort_fail", int'(fc_s[0]), 32);
        check("abort_chk", int'(cc_s[0]), 32);
        check("abort_first", int'(ff_s[0]), 1);
        @(posedge clk);
        #1;
        check("abort_idle", int'(busy_s[0]), 0);
        run_sweep(0, 0, n);
        check("rearm_cycles", n, 256);
        check("rearm_fail", int'(fc_s[0]), 0);
        check("rearm_chk", int'(cc_s[0]), 256);
        check("rearm_pass", int'(pass_s[0]), 1);
`endif

        // Simultaneous start and abort in DONE: abort wins
        start_s[0] = 1'b1;
        abort_s[0] = 1'b1;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        abort_s[0] = 1'b0;
        check("sa_done", int'(done_s[0]), 0);
        check("sa_busy", int'(busy_s[0]), 0);
        check("sa_pass", int'(pass_s[0]), 0);
        @(posedge clk);
        #1;
        check("sa_idle", int'(busy_s[0]), 0);

        // Reset mid-sweep at vec=0x80
        mode[0] = 0;
        start_s[0] = 1'b1;
        @(posedge clk);
        #1 start_s[0] = 1'b0;
        wait_vec(0, 8'h80);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_vec", int'(vec_s[0]), 0);
        check("mrst_busy", int'(busy_s[0]), 0);
        check("mrst_chk", int'(cc_s[0]), 0);
        check("mrst_done", int'(done_s[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_idle", int'(busy_s[0]), 0);
        run_sweep(0, 0, n);
        check("mrst_cycles", n, 256);
        check("mrst_pass", int'(pass_s[0]), 1);
        check("mrst_chk256", int'(cc_s[0]), 256);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
